// File: rtl/nes_palette_mapper_pkg.sv
// Shared types, sizes and the NES master colour table for the palette mapper.
package nes_vga_pkg;

  typedef logic [4:0] pal_idx_t;
  typedef logic [5:0] master_idx_t;

  localparam int unsigned NES_W = 256;
  localparam int unsigned NES_H = 240;
  localparam master_idx_t PAL_RESET = 6'h0F;

  // 2C02 master palette, 24-bit RGB, indexed by the 6-bit master index.
  localparam logic [23:0] MASTER_PAL [64] = '{
    24'h7C7C7C, 24'h0000FC, 24'h0000BC, 24'h4428BC, 24'h940084, 24'hA80020, 24'hA81000,
    24'h881400, 24'h503000, 24'h007800, 24'h006800, 24'h005800, 24'h004058, 24'h000000,
    24'h000000, 24'h000000,
    24'hBCBCBC, 24'h0078F8, 24'h0058F8, 24'h6844FC, 24'hD800CC, 24'hE40058, 24'hF83800,
    24'hE45C10, 24'hAC7C00, 24'h00B800, 24'h00A800, 24'h00A844, 24'h008888, 24'h000000,
    24'h000000, 24'h000000,
    24'hF8F8F8, 24'h3CBCFC, 24'h6888FC, 24'h9878F8, 24'hF878F8, 24'hF85898, 24'hF87858,
    24'hFCA044, 24'hF8B800, 24'hB8F818, 24'h58D854, 24'h58F898, 24'h00E8D8, 24'h787878,
    24'h000000, 24'h000000,
    24'hFCFCFC, 24'hA4E4FC, 24'hB8B8F8, 24'hD8B8F8, 24'hF8B8F8, 24'hF8A4C0, 24'hF0D0B0,
    24'hFCE0A8, 24'hF8D878, 24'hD8F878, 24'hB8F8B8, 24'hB8F8D8, 24'h00FCFC, 24'hF8D8F8,
    24'h000000, 24'h000000
  };

  // Sprite backdrop slots 10/14/18/1C alias the background backdrop slots 00/04/08/0C.
  function automatic pal_idx_t pal_mirror(pal_idx_t a);
    return (a[4] && (a[1:0] == 2'b00)) ? {1'b0, a[3:0]} : a;
  endfunction

endpackage

// File: rtl/nes_palette_mapper_if.sv
// VGA-side, framebuffer-fetch and palette-write signals of the palette mapper.
interface nes_palette_mapper_if #(
  parameter int unsigned COLOR_W = 8
);
  logic [9:0]         DrawX;
  logic [9:0]         DrawY;
  logic               blank_n;
  logic [7:0]         fb_x;
  logic [7:0]         fb_y;
  logic [4:0]         pal_idx;
  logic               pal_we;
  logic [4:0]         pal_waddr;
  logic [5:0]         pal_wdata;
  logic [2:0]         emphasis;
  logic               in_active;
  logic [COLOR_W-1:0] VGA_R;
  logic [COLOR_W-1:0] VGA_G;
  logic [COLOR_W-1:0] VGA_B;

  // Driver side: VGA timing, PPU pixel store and palette writer.
  modport master (
    output DrawX, DrawY, blank_n, pal_idx, pal_we, pal_waddr, pal_wdata, emphasis,
    input  fb_x, fb_y, in_active, VGA_R, VGA_G, VGA_B
  );

  // Mapper side.
  modport slave (
    input  DrawX, DrawY, blank_n, pal_idx, pal_we, pal_waddr, pal_wdata, emphasis,
    output fb_x, fb_y, in_active, VGA_R, VGA_G, VGA_B
  );
endinterface

// File: rtl/nes_palette_mapper_rom.sv
// Registered master colour lookup (stage 3); clr_i forces black for blanked pixels.
module nes_master_rom
  import nes_vga_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        clr_i,
  input  master_idx_t idx_i,
  output logic [23:0] rgb_o
);

  logic [23:0] rgb_d, rgb_q;

  // Table lookup, masked to black during blanking.
  always_comb begin
    rgb_d = clr_i ? 24'h000000 : MASTER_PAL[idx_i];
  end

  // Output register with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) rgb_q <= '0;
    else       rgb_q <= rgb_d;
  end

  assign rgb_o = rgb_q;

endmodule

// File: rtl/nes_palette_mapper.sv
// NES palette mapper: VGA pixel -> NES window coordinate -> palette RAM -> master ROM -> RGB.
// Three-stage pipeline. Optional per-frame colour emphasis when NES_EMPHASIS_EN is defined.
module nes_palette_mapper
  import nes_vga_pkg::*;
#(
  parameter int unsigned COLOR_W = 8,
  parameter int unsigned SCALE   = 2,
  parameter int unsigned H_OFF   = 64,
  parameter int unsigned V_OFF   = 0
) (
  input logic                 Clk,
  input logic                 Reset,
  nes_palette_mapper_if.slave bus
);

  localparam int unsigned Shift = (SCALE == 2) ? 1 : 0;

  if ((SCALE != 1) && (SCALE != 2)) begin : g_bad_scale
    $error("nes_palette_mapper: SCALE must be 1 or 2");
  end

  // Stage 1 state
  logic        act1_d, act1_q, blank1_d, blank1_q;
  logic [7:0]  fb_x_d, fb_x_q, fb_y_d, fb_y_q;
  logic [10:0] dx, dy;
  // Stage 2 state
  master_idx_t pal_d [32];
  master_idx_t pal_q [32];
  master_idx_t mid2_d, mid2_q;
  logic        act2_d, act2_q, blank2_d, blank2_q;
  pal_idx_t    rd_addr, wr_addr;
  // Stage 3 state
  logic        act3_d, act3_q;
  logic [23:0] rgb;

  // Window test and framebuffer coordinate; an 11-bit difference makes left/top misses negative.
  always_comb begin
    dx       = {1'b0, bus.DrawX} - 11'(H_OFF);
    dy       = {1'b0, bus.DrawY} - 11'(V_OFF);
    act1_d   = bus.blank_n && !dx[10] && (dx < 11'(NES_W * SCALE))
                           && !dy[10] && (dy < 11'(NES_H * SCALE));
    blank1_d = bus.blank_n;
    fb_x_d   = '0;
    fb_y_d   = '0;
    if (act1_d) begin
      fb_x_d = 8'(dx[9:0] >> Shift);
      fb_y_d = 8'(dy[9:0] >> Shift);
    end
  end

  // Palette RAM write and write-first read; border and backdrop pixels read entry 0.
  always_comb begin
    rd_addr = (act1_q && (bus.pal_idx[1:0] != 2'b00)) ? bus.pal_idx : '0;
    wr_addr = pal_mirror(bus.pal_waddr);
    pal_d   = pal_q;
    if (bus.pal_we) pal_d[wr_addr] = bus.pal_wdata;
    mid2_d   = pal_d[rd_addr];
    act2_d   = act1_q;
    blank2_d = blank1_q;
    act3_d   = act2_q;
  end

  // Pipeline and palette registers.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      act1_q   <= 1'b0;
      blank1_q <= 1'b0;
      fb_x_q   <= '0;
      fb_y_q   <= '0;
      mid2_q   <= '0;
      act2_q   <= 1'b0;
      blank2_q <= 1'b0;
      act3_q   <= 1'b0;
      for (int i = 0; i < 32; i++) pal_q[i] <= PAL_RESET;
    end else begin
      act1_q   <= act1_d;
      blank1_q <= blank1_d;
      fb_x_q   <= fb_x_d;
      fb_y_q   <= fb_y_d;
      mid2_q   <= mid2_d;
      act2_q   <= act2_d;
      blank2_q <= blank2_d;
      act3_q   <= act3_d;
      pal_q    <= pal_d;
    end
  end

  nes_master_rom u_rom (
    .clk_i (Clk),
    .rst_i (Reset),
    .clr_i (!blank2_q),
    .idx_i (mid2_q),
    .rgb_o (rgb)
  );

  logic [COLOR_W-1:0] r_raw, g_raw, b_raw, r_out, g_out, b_out;
  assign r_raw = rgb[23 -: COLOR_W];
  assign g_raw = rgb[15 -: COLOR_W];
  assign b_raw = rgb[7 -: COLOR_W];

`ifdef NES_EMPHASIS_EN
  // emph_q doubles as the stage-1 tag: it is what the pixel sampled on this edge sees.
  logic [2:0] emph_d, emph_q, emph2_d, emph2_q, emph3_d, emph3_q;

  // Latch emphasis once per frame and carry it alongside the pixel.
  always_comb begin
    emph_d  = ((bus.DrawX == 10'd0) && (bus.DrawY == 10'd0)) ? bus.emphasis : emph_q;
    emph2_d = emph_q;
    emph3_d = emph2_q;
  end

  // Emphasis registers.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      emph_q  <= '0;
      emph2_q <= '0;
      emph3_q <= '0;
    end else begin
      emph_q  <= emph_d;
      emph2_q <= emph2_d;
      emph3_q <= emph3_d;
    end
  end

  // Attenuate the non-emphasised channels to 3/4 when any emphasis bit is set.
  always_comb begin
    r_out = r_raw;
    g_out = g_raw;
    b_out = b_raw;
    if (emph3_q != 3'b000) begin
      if (!emph3_q[0]) r_out = r_raw - (r_raw >> 2);
      if (!emph3_q[1]) g_out = g_raw - (g_raw >> 2);
      if (!emph3_q[2]) b_out = b_raw - (b_raw >> 2);
    end
  end
`else
  logic unused_emphasis;
  assign unused_emphasis = ^bus.emphasis;

  // Colour passes straight through.
  always_comb begin
    r_out = r_raw;
    g_out = g_raw;
    b_out = b_raw;
  end
`endif

  assign bus.fb_x      = fb_x_q;
  assign bus.fb_y      = fb_y_q;
  assign bus.in_active = act3_q;
  assign bus.VGA_R     = r_out;
  assign bus.VGA_G     = g_out;
  assign bus.VGA_B     = b_out;

endmodule

// File: tb/tb_nes_palette_mapper.sv
// Randomized scoreboard bench for nes_palette_mapper (SCALE=2, H_OFF=64, V_OFF=0).
module tb_nes_palette_mapper;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  nes_palette_mapper_if #(.COLOR_W(8)) bus ();

  nes_palette_mapper #(
    .COLOR_W (8),
    .SCALE   (2),
    .H_OFF   (64),
    .V_OFF   (0)
  ) dut (
    .Clk   (clk),
    .Reset (rst),
    .bus   (bus)
  );

  // Reference NES master palette.
  localparam bit [23:0] REF_ROM [64] = '{
    24'h7C7C7C, 24'h0000FC, 24'h0000BC, 24'h4428BC, 24'h940084, 24'hA80020, 24'hA81000,
    24'h881400, 24'h503000, 24'h007800, 24'h006800, 24'h005800, 24'h004058, 24'h000000,
    24'h000000, 24'h000000,
    24'hBCBCBC, 24'h0078F8, 24'h0058F8, 24'h6844FC, 24'hD800CC, 24'hE40058, 24'hF83800,
    24'hE45C10, 24'hAC7C00, 24'h00B800, 24'h00A800, 24'h00A844, 24'h008888, 24'h000000,
    24'h000000, 24'h000000,
    24'hF8F8F8, 24'h3CBCFC, 24'h6888FC, 24'h9878F8, 24'hF878F8, 24'hF85898, 24'hF87858,
    24'hFCA044, 24'hF8B800, 24'hB8F818, 24'h58D854, 24'h58F898, 24'h00E8D8, 24'h787878,
    24'h000000, 24'h000000,
    24'hFCFCFC, 24'hA4E4FC, 24'hB8B8F8, 24'hD8B8F8, 24'hF8B8F8, 24'hF8A4C0, 24'hF0D0B0,
    24'hFCE0A8, 24'hF8D878, 24'hD8F878, 24'hB8F8B8, 24'hB8F8D8, 24'h00FCFC, 24'hF8D8F8,
    24'h000000, 24'h000000
  };

  typedef struct { int due; int fx; int fy; } fb_exp_t;
  typedef struct { int due; bit act; int r; int g; int b; } pix_exp_t;
  typedef struct { int due; bit act; bit blank; int fx; int fy; logic [2:0] emph; } pend_t;

  int       cyc = 0;
  int       checks = 0;
  int       errors = 0;
  int       seed_v = 0;
  int       mpal [32];
  logic [2:0] memph;
  pend_t    pend;
  bit       pend_v;
  fb_exp_t  fbq [$];
  pix_exp_t pixq [$];
  int       rstq [$];

  // Upstream pixel store: a deterministic pattern over framebuffer coordinates.
  function automatic logic [4:0] fbpix(input int x, input int y, input int s);
    return 5'(x * 3 + y * 7 + s);
  endfunction

  assign bus.pal_idx = fbpix(int'(bus.fb_x), int'(bus.fb_y), seed_v);

  always @(posedge clk) cyc <= cyc + 1;

  // Palette read happens one cycle after issue, so it sees that cycle's write.
  function automatic pix_exp_t resolve(input pend_t p);
    pix_exp_t e;
    int idx, addr, col;
    int ch [3];
    idx  = int'(fbpix(p.fx, p.fy, seed_v));
    addr = (!p.act || (idx % 4 == 0)) ? 0 : idx;
    col  = p.blank ? 0 : int'(REF_ROM[mpal[addr]]);
    ch[0] = (col >> 16) & 255;
    ch[1] = (col >> 8) & 255;
    ch[2] = col & 255;
`ifdef NES_EMPHASIS_EN
    if (p.emph != 3'b000) begin
      for (int k = 0; k < 3; k++) if (!p.emph[k]) ch[k] = ch[k] - ch[k] / 4;
    end
`endif
    e.due = p.due;
    e.act = p.act;
    e.r   = ch[0];
    e.g   = ch[1];
    e.b   = ch[2];
    return e;
  endfunction

  task automatic issue(input int x, input int y, input bit bl, input bit we, input int wa,
                       input int wd, input logic [2:0] em);
    pend_t cur;
    @(posedge clk);
    #1;
    rst           = 1'b0;
    bus.DrawX     = 10'(x);
    bus.DrawY     = 10'(y);
    bus.blank_n   = bl;
    bus.pal_we    = we;
    bus.pal_waddr = 5'(wa);
    bus.pal_wdata = 6'(wd);
    bus.emphasis  = em;
    if (we) mpal[(wa >= 16 && wa % 4 == 0) ? wa - 16 : wa] = wd;
    if (pend_v) pixq.push_back(resolve(pend));
    cur.due   = cyc + 3;
    cur.act   = bl && x >= 64 && x < 64 + 256 * 2 && y < 240 * 2;
    cur.blank = !bl;
    cur.fx    = cur.act ? (x - 64) / 2 : 0;
    cur.fy    = cur.act ? y / 2 : 0;
    if (x == 0 && y == 0) memph = em;
    cur.emph  = memph;
    fbq.push_back('{cyc + 1, cur.fx, cur.fy});
    pend   = cur;
    pend_v = 1'b1;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst         = 1'b1;
    bus.pal_we  = 1'b0;
    bus.blank_n = 1'b0;
    bus.DrawX   = '0;
    bus.DrawY   = '0;
    fbq.delete();
    pixq.delete();
    pend_v = 1'b0;
    for (int i = 0; i < 32; i++) mpal[i] = 15;
    memph  = 3'b000;
    seed_v = int'($urandom_range(0, 31));
    rstq.push_back(cyc + 1);
    rstq.push_back(cyc + 2);
    @(posedge clk);
    #1;
  endtask

  // Monitor: compares each expected item in the cycle it falls due.
  always @(negedge clk) begin
    if (rstq.size() > 0 && rstq[0] <= cyc) begin
      checks = checks + 1;
      if (rstq[0] < cyc || {bus.fb_x, bus.fb_y, bus.in_active, bus.VGA_R, bus.VGA_G,
                            bus.VGA_B} !== 41'd0) begin
        errors = errors + 1;
        $display("FAIL reset_state cyc=%0d got fb=%0d,%0d act=%0b rgb=%02h%02h%02h want all 0",
                 cyc, bus.fb_x, bus.fb_y, bus.in_active, bus.VGA_R, bus.VGA_G, bus.VGA_B);
      end
      void'(rstq.pop_front());
    end
    if (fbq.size() > 0 && fbq[0].due <= cyc) begin
      checks = checks + 1;
      if (fbq[0].due < cyc || int'(bus.fb_x) != fbq[0].fx || int'(bus.fb_y) != fbq[0].fy) begin
        errors = errors + 1;
        $display("FAIL fb_coord cyc=%0d got %0d,%0d want %0d,%0d (due %0d)", cyc, bus.fb_x,
                 bus.fb_y, fbq[0].fx, fbq[0].fy, fbq[0].due);
      end
      void'(fbq.pop_front());
    end
    if (pixq.size() > 0 && pixq[0].due <= cyc) begin
      checks = checks + 1;
      if (pixq[0].due < cyc || bus.in_active !== pixq[0].act || int'(bus.VGA_R) != pixq[0].r ||
          int'(bus.VGA_G) != pixq[0].g || int'(bus.VGA_B) != pixq[0].b) begin
        errors = errors + 1;
        $display("FAIL pixel cyc=%0d got act=%0b rgb=%02h%02h%02h want act=%0b rgb=%02h%02h%02h",
                 cyc, bus.in_active, bus.VGA_R, bus.VGA_G, bus.VGA_B, pixq[0].act,
                 pixq[0].r[7:0], pixq[0].g[7:0], pixq[0].b[7:0]);
      end
      void'(pixq.pop_front());
    end
  end

  int xs [14] = '{0, 10, 60, 62, 64, 100, 300, 510, 570, 574, 575, 576, 600, 798};
  int ys [10] = '{0, 1, 100, 238, 239, 240, 478, 479, 480, 524};

  initial begin
    int x, y;
    bit bl;
    rst           = 1'b1;
    bus.DrawX     = '0;
    bus.DrawY     = '0;
    bus.blank_n   = 1'b0;
    bus.pal_we    = 1'b0;
    bus.pal_waddr = '0;
    bus.pal_wdata = '0;
    bus.emphasis  = '0;
    for (int run = 0; run < 3; run++) begin
      do_reset();
      for (int blk = 0; blk < 25; blk++) begin
        x = xs[$urandom_range(0, 13)];
        y = ys[$urandom_range(0, 9)];
        for (int k = 0; k < 60; k++) begin
          bl = (x < 640) && (y < 480) && ($urandom_range(0, 19) != 0);
          issue(x, y, bl, ($urandom_range(0, 3) == 0), int'($urandom_range(0, 31)),
                int'($urandom_range(0, 63)), 3'($urandom_range(0, 7)));
          x++;
          if (x == 800) begin
            x = 0;
            y = (y == 524) ? 0 : y + 1;
          end
        end
      end
    end
    for (int k = 0; k < 4; k++) issue(700, 500, 1'b0, 1'b0, 0, 0, 3'b000);
    repeat (6) @(posedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
